// File: rtl/bus_sequencer_pkg.sv
// bus_sequencer_pkg: command codes, FSM states and byte-lane helper shared by bus_sequencer
package bus_sequencer_pkg;
  localparam logic [1:0] BUS_SEQX_IDLE  = 2'd0;
  localparam logic [1:0] BUS_SEQX_FETCH = 2'd1;
  localparam logic [1:0] BUS_SEQX_READ  = 2'd2;
  localparam logic [1:0] BUS_SEQX_WRITE = 2'd3;
  localparam logic BYTEX_BYTE = 1'b1;
  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_FINISH} state_t;
  function automatic logic [1:0] lane_be(input logic is_byte, input logic odd);
    return is_byte ? (odd ? 2'b10 : 2'b01) : 2'b11;
  endfunction
endpackage

// File: rtl/bus_sequencer.sv
// bus_sequencer: runs one FETCH/READ/WRITE strobe cycle on a 16-bit memory bus
//   CLK/RESET           clock, asynchronous active-high reset
//   START, BUS_SEQX     request pulse and command (IDLE/FETCH/READ/WRITE)
//   BYTEX, ADDR, DOUT   access size, byte address, write data (latched on START)
//   MEM_*               memory bus: word address, write data, strobes, byte enables, read data, wait
//   INSTR, DIN          last fetched instruction / last read data (byte reads zero-extended)
//   BUSY, DONE, BUS_ERR status; BUS_ERR is a sticky timeout flag
//   Define BUS_SEQ_TIMEOUT_EN to abort STROBE after TIMEOUT_CYCLES wait cycles.
module bus_sequencer
  import bus_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
`ifdef BUS_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic [1:0]            BUS_SEQX,
  input  logic                  BYTEX,
  input  logic [ADDR_WIDTH-1:0] ADDR,
  input  logic [15:0]           DOUT,
  input  logic [15:0]           MEM_DIN,
  input  logic                  MEM_WAIT,
  output logic [ADDR_WIDTH-2:0] MEM_ADDR,
  output logic [15:0]           MEM_DOUT,
  output logic                  MEM_RD,
  output logic                  MEM_WR,
  output logic [1:0]            MEM_BE,
  output logic [15:0]           INSTR,
  output logic [15:0]           DIN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  BUS_ERR
);
  state_t state, state_nx;
  logic [1:0] op;
  logic is_byte, odd, idle_done, go, go_idle, byte_in, cap, abort;
  assign go = START && state == ST_IDLE && BUS_SEQX != BUS_SEQX_IDLE;
  assign go_idle = START && state == ST_IDLE && BUS_SEQX == BUS_SEQX_IDLE;
  assign byte_in = BYTEX == BYTEX_BYTE && BUS_SEQX != BUS_SEQX_FETCH;
  assign cap = state == ST_STROBE && !MEM_WAIT;
  // strobes and status decode straight from state so RESET drops them without a clock
  assign MEM_RD = state == ST_STROBE && op != BUS_SEQX_WRITE;
  assign MEM_WR = state == ST_STROBE && op == BUS_SEQX_WRITE;
  assign BUSY = state == ST_SETUP || state == ST_STROBE;
  assign DONE = state == ST_FINISH || idle_done;
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   state_nx = go ? ST_SETUP : ST_IDLE;
      ST_SETUP:  state_nx = ST_STROBE;
      ST_STROBE: state_nx = (!MEM_WAIT || abort) ? ST_FINISH : ST_STROBE;
      default:   state_nx = ST_IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= ST_IDLE;
      op <= BUS_SEQX_IDLE;
      is_byte <= 1'b0;
      odd <= 1'b0;
      idle_done <= 1'b0;
      MEM_ADDR <= '0;
      MEM_DOUT <= '0;
      MEM_BE <= 2'b00;
      INSTR <= '0;
      DIN <= '0;
    end else begin
      state <= state_nx;
      idle_done <= go_idle;
      if (go) begin
        op <= BUS_SEQX;
        is_byte <= byte_in;
        odd <= ADDR[0];
        MEM_ADDR <= ADDR[ADDR_WIDTH-1:1];
        MEM_DOUT <= byte_in ? {2{DOUT[7:0]}} : DOUT;
        MEM_BE <= lane_be(byte_in, ADDR[0]);
      end
      if (cap && op == BUS_SEQX_FETCH) INSTR <= MEM_DIN;
      if (cap && op == BUS_SEQX_READ)
        DIN <= is_byte ? {8'h00, odd ? MEM_DIN[15:8] : MEM_DIN[7:0]} : MEM_DIN;
    end
  end
`ifdef BUS_SEQ_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic err;
  // wait_cnt holds the number of stalled STROBE cycles already completed
  assign abort = state == ST_STROBE && MEM_WAIT && wait_cnt == 8'(TIMEOUT_CYCLES - 1);
  assign BUS_ERR = err;
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wait_cnt <= 8'd0;
      err <= 1'b0;
    end else begin
      wait_cnt <= (state == ST_STROBE && MEM_WAIT) ? wait_cnt + 8'd1 : 8'd0;
      err <= err | abort;
    end
  end
`else
  assign abort = 1'b0;
  assign BUS_ERR = 1'b0;
`endif
endmodule

// File: tb/tb_bus_sequencer.sv
// tb_bus_sequencer: directed bench with a transaction-timeline model of bus_sequencer
module tb_bus_sequencer;
  localparam int TO = 8;
  logic CLK = 0, RESET = 1, START = 0, BYTEX = 0, MEM_WAIT = 0;
  logic [1:0] BUS_SEQX = 0;
  logic [15:0] ADDR = 0, DOUT = 0, MEM_DIN = 0;
  logic [14:0] MEM_ADDR;
  logic [15:0] MEM_DOUT, INSTR, DIN;
  logic MEM_RD, MEM_WR, BUSY, DONE, BUS_ERR;
  logic [1:0] MEM_BE;

`ifdef BUS_SEQ_TIMEOUT_EN
  bus_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
`else
  bus_sequencer dut (
`endif
    .CLK(CLK), .RESET(RESET), .START(START), .BUS_SEQX(BUS_SEQX), .BYTEX(BYTEX),
    .ADDR(ADDR), .DOUT(DOUT), .MEM_DIN(MEM_DIN), .MEM_WAIT(MEM_WAIT),
    .MEM_ADDR(MEM_ADDR), .MEM_DOUT(MEM_DOUT), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR),
    .MEM_BE(MEM_BE), .INSTR(INSTR), .DIN(DIN), .BUSY(BUSY), .DONE(DONE), .BUS_ERR(BUS_ERR)
  );

  always #5 CLK = ~CLK;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // model: one accepted transaction starts at cycle t0; with nw stall cycles the
  // strobe spans t0+2..t0+2+nw and DONE lands at t0+3+nw
  bit act = 0, m_byte = 0, exp_err = 0;
  int t0 = 0, nw = 0, t_idle = -100;
  logic [1:0] m_op = 0;
  logic [15:0] m_addr = 0, m_dout = 0, exp_instr = 0, exp_din = 0;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  always @(negedge CLK) begin
    int rel;
    bit st;
    if (!RESET) begin
      rel = cyc - t0;
      st = act && rel >= 2 && rel <= 2 + nw;
      chk("mem_rd", 16'(MEM_RD), 16'(st && m_op != 2'd3));
      chk("mem_wr", 16'(MEM_WR), 16'(st && m_op == 2'd3));
      chk("busy", 16'(BUSY), 16'(act && rel >= 1 && rel <= 2 + nw));
      chk("done", 16'(DONE), 16'((act && rel == 3 + nw) || cyc == t_idle + 1));
      chk("instr", INSTR, exp_instr);
      chk("din", DIN, exp_din);
      chk("bus_err", 16'(BUS_ERR), 16'(exp_err));
      if (act && rel >= 1) begin
        chk("mem_addr", {1'b0, MEM_ADDR}, {1'b0, m_addr[15:1]});
        chk("mem_be", 16'(MEM_BE), !m_byte ? 16'd3 : (m_addr[0] ? 16'd2 : 16'd1));
        chk("mem_dout", MEM_DOUT, m_byte ? {m_dout[7:0], m_dout[7:0]} : m_dout);
      end
    end
  end

  task automatic run(input logic [1:0] o, input logic b, input logic [15:0] a, d, m,
                     input int w, input bit noise, input bit ab);
    @(posedge CLK); #2;
    BUS_SEQX = o; BYTEX = b; ADDR = a; DOUT = d; MEM_DIN = m; START = 1;
    if (o == 2'd0) begin
      t_idle = cyc;
      @(posedge CLK); #2;
      START = 0;
      @(posedge CLK); #2;
    end else begin
      act = 1; t0 = cyc; m_op = o; m_byte = b && o != 2'd1; m_addr = a; m_dout = d; nw = w;
      @(posedge CLK); #2;
      START = noise; BUS_SEQX = 2'd3; ADDR = ~a; DOUT = ~d; BYTEX = !b;
      @(posedge CLK); #2;
      START = 0; MEM_WAIT = (w > 0) || ab;
      for (int i = 1; i <= w; i++) begin
        @(posedge CLK); #2;
        MEM_WAIT = (i < w) || ab;
        START = noise && i == 1;
      end
      @(posedge CLK); #2;
      MEM_WAIT = 0; START = noise;
      if (ab) exp_err = 1;
      else if (o == 2'd1) exp_instr = m;
      else if (o == 2'd2) exp_din = m_byte ? (a[0] ? {8'h00, m[15:8]} : {8'h00, m[7:0]}) : m;
      @(posedge CLK); #2;
      START = 0;
    end
  endtask

  task automatic stuck(input logic [1:0] o, input logic [15:0] a, d, input int cycles);
    @(posedge CLK); #2;
    BUS_SEQX = o; BYTEX = 0; ADDR = a; DOUT = d; START = 1;
    act = 1; t0 = cyc; m_op = o; m_byte = 0; m_addr = a; m_dout = d; nw = 1000;
    @(posedge CLK); #2;
    START = 0;
    @(posedge CLK); #2;
    MEM_WAIT = 1;
    repeat (cycles) @(posedge CLK);
    #2;
  endtask

  task automatic hit_reset();
    RESET = 1;
    act = 0; exp_instr = 0; exp_din = 0; exp_err = 0;
    #1;
    chk("rst_mem_rd", 16'(MEM_RD), 16'd0);
    chk("rst_mem_wr", 16'(MEM_WR), 16'd0);
    chk("rst_busy", 16'(BUSY), 16'd0);
    chk("rst_done", 16'(DONE), 16'd0);
    chk("rst_mem_addr", {1'b0, MEM_ADDR}, 16'd0);
    MEM_WAIT = 0;
    @(posedge CLK); #2;
    RESET = 0;
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #2;
    chk("init_mem_addr", {1'b0, MEM_ADDR}, 16'd0);
    chk("init_mem_be", 16'(MEM_BE), 16'd0);
    chk("init_instr", INSTR, 16'd0);
    chk("init_din", DIN, 16'd0);
    chk("init_done", 16'(DONE), 16'd0);
    RESET = 0;
    run(2'd1, 1'b1, 16'h0102, 16'h0000, 16'hBEEF, 0, 0, 0);
    chk("t1_instr", INSTR, 16'hBEEF);
    chk("t1_mem_addr", {1'b0, MEM_ADDR}, 16'h0081);
    chk("t1_din", DIN, 16'h0000);
    run(2'd2, 1'b1, 16'h0013, 16'h0000, 16'hA55A, 0, 0, 0);
    chk("t2_din_hi", DIN, 16'h00A5);
    chk("t2_be_hi", 16'(MEM_BE), 16'd2);
    run(2'd2, 1'b1, 16'h0012, 16'h0000, 16'hA55A, 0, 0, 0);
    chk("t2_din_lo", DIN, 16'h005A);
    chk("t2_be_lo", 16'(MEM_BE), 16'd1);
    run(2'd3, 1'b1, 16'h0021, 16'h1234, 16'h0000, 0, 0, 0);
    chk("t3_dout_byte", MEM_DOUT, 16'h3434);
    chk("t3_be_byte", 16'(MEM_BE), 16'd2);
    run(2'd3, 1'b0, 16'h0021, 16'h1234, 16'h0000, 0, 0, 0);
    chk("t3_dout_word", MEM_DOUT, 16'h1234);
    chk("t3_be_word", 16'(MEM_BE), 16'd3);
    run(2'd2, 1'b0, 16'h0013, 16'h0000, 16'hC3D2, 2, 0, 0);
    chk("word_read", DIN, 16'hC3D2);
    run(2'd1, 1'b1, 16'h0103, 16'h0000, 16'h1357, 1, 0, 0);
    chk("fetch_odd_be", 16'(MEM_BE), 16'd3);
    run(2'd2, 1'b0, 16'h0040, 16'h0000, 16'h5A5A, 4, 1, 0);
    chk("t4_din", DIN, 16'h5A5A);
    stuck(2'd3, 16'h0200, 16'hCAFE, 2);
    chk("t5_wr_high", 16'(MEM_WR), 16'd1);
    hit_reset();
    run(2'd0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
`ifdef BUS_SEQ_TIMEOUT_EN
    run(2'd2, 1'b0, 16'h0050, 16'h0000, 16'h9999, TO - 1, 0, 1);
    chk("t6_err", 16'(BUS_ERR), 16'd1);
    chk("t6_din", DIN, 16'h0000);
    run(2'd2, 1'b0, 16'h0052, 16'h0000, 16'h1111, 0, 0, 0);
    chk("t6_err_sticky", 16'(BUS_ERR), 16'd1);
`else
    stuck(2'd2, 16'h0050, 16'h0000, 20);
    chk("t6_rd_stuck", 16'(MEM_RD), 16'd1);
    chk("t6_no_err", 16'(BUS_ERR), 16'd0);
    hit_reset();
`endif
    repeat (3) @(posedge CLK);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
